// File: rtl/vga_box_compositor_if.sv
// Box descriptor bus for vga_box_compositor.
// The master side (display control) drives one descriptor per box plus the
// live background colour; the compositor is the slave and only ever reads.
//   box_en    [NUM_BOXES]      per-box enable
//   box_blink [NUM_BOXES]      per-box blink mode
//   box_x     [NUM_BOXES*10]   centre x, box i at [10i+9:10i]
//   box_y     [NUM_BOXES*9]    centre y, box i at [9i+8:9i]
//   box_half  [NUM_BOXES*8]    half-size, box i at [8i+7:8i]
//   box_color [NUM_BOXES*12]   RGB444, box i at [12i+11:12i]
//   bg_color  [12]             background RGB444, never shadowed
interface vga_box_compositor_if #(
   parameter int NUM_BOXES = 4
);
   logic [NUM_BOXES-1:0]    box_en;
   logic [NUM_BOXES-1:0]    box_blink;
   logic [NUM_BOXES*10-1:0] box_x;
   logic [NUM_BOXES*9-1:0]  box_y;
   logic [NUM_BOXES*8-1:0]  box_half;
   logic [NUM_BOXES*12-1:0] box_color;
   logic [11:0]             bg_color;

   modport master (
      output box_en, box_blink, box_x, box_y, box_half, box_color, bg_color
   );

   modport slave (
      input box_en, box_blink, box_x, box_y, box_half, box_color, bg_color
   );
endinterface

// File: rtl/vga_box_compositor.sv
// VGA timing generator with a fixed-priority multi-box compositor.
// Box descriptors are shadowed once per frame (on the last clock of the frame)
// so a frame is never drawn with a half-updated descriptor set. Colour passes
// through a 2-stage pipeline (hit test, then priority select) and the syncs
// are delayed by the same two clocks.
// Ports:
//   clk_25mHz    pixel clock
//   reset        synchronous, active-high
//   cfg          box descriptor bus (slave)
//   hSync/vSync  active-low syncs, aligned with colour
//   VGA_R/G/B    pixel colour, 0 outside the active region
//   screenEnd    undelayed one-clock pulse on the last clock of each frame
//   frame_cnt    8-bit wrapping frame counter
module vga_box_compositor #(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int NUM_BOXES   = 4,
   parameter int BLINK_SHIFT = 4
) (
   input  logic                 clk_25mHz,
   input  logic                 reset,
   vga_box_compositor_if.slave  cfg,
   output logic                 hSync,
   output logic                 vSync,
   output logic [3:0]           VGA_R,
   output logic [3:0]           VGA_G,
   output logic [3:0]           VGA_B,
   output logic                 screenEnd,
   output logic [7:0]           frame_cnt
);
   localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  W_LIM  = 10'(WIDTH);
   localparam logic [9:0]  V_LIM  = 10'(HEIGHT);
   localparam logic [9:0]  HS_BEG = 10'(WIDTH + H_FP);
   localparam logic [9:0]  HS_END = 10'(WIDTH + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG = 10'(HEIGHT + V_FP);
   localparam logic [9:0]  VS_END = 10'(HEIGHT + V_FP + V_SYNC);
   localparam logic [10:0] X_MAX  = 11'(WIDTH - 1);
   localparam logic [10:0] Y_MAX  = 11'(HEIGHT - 1);
   localparam logic [10:0] X_LIM  = 11'(WIDTH);
   localparam logic [10:0] Y_LIM  = 11'(HEIGHT);

   logic [9:0]              h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [7:0]              frame_cnt_q, frame_cnt_d;
   logic [NUM_BOXES-1:0]    sh_en_q, sh_en_d, sh_blink_q, sh_blink_d;
   logic [NUM_BOXES*10-1:0] sh_x_q, sh_x_d;
   logic [NUM_BOXES*9-1:0]  sh_y_q, sh_y_d;
   logic [NUM_BOXES*8-1:0]  sh_half_q, sh_half_d;
   logic [NUM_BOXES*12-1:0] sh_color_q, sh_color_d;
   logic [NUM_BOXES-1:0]    hit_q, hit_d;
   logic                    act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic [11:0]             rgb_q, rgb_d;
   logic                    hs2_q, hs2_d, vs2_q, vs2_d;

   logic                    frame_end;
   logic [11:0]             pix;
   logic [10:0]             h_ext, v_ext;
   logic [10:0]             left [NUM_BOXES];
   logic [10:0]             right [NUM_BOXES];
   logic [10:0]             top [NUM_BOXES];
   logic [10:0]             bottom [NUM_BOXES];
   logic [NUM_BOXES-1:0]    drawable;

   assign h_ext = {1'b0, h_cnt_q};
   assign v_ext = {1'b0, v_cnt_q};

   // Per-box bounds from the shadow copy; 11-bit math so x+half cannot wrap
   // before the clamp to the last visible column/row.
   for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
      logic [10:0] bx, by, bh, x_sum, y_sum;
      assign bx        = {1'b0, sh_x_q[10*i +: 10]};
      assign by        = {2'b0, sh_y_q[9*i +: 9]};
      assign bh        = {3'b0, sh_half_q[8*i +: 8]};
      assign x_sum     = bx + bh;
      assign y_sum     = by + bh;
      assign left[i]   = (bx >= bh) ? bx - bh : 11'd0;
      assign right[i]  = (x_sum > X_MAX) ? X_MAX : x_sum;
      assign top[i]    = (by >= bh) ? by - bh : 11'd0;
      assign bottom[i] = (y_sum > Y_MAX) ? Y_MAX : y_sum;
      // A centre off-screen disqualifies the box even if its extent overlaps.
      assign drawable[i] = sh_en_q[i] && !(sh_blink_q[i] && frame_cnt_q[BLINK_SHIFT])
                           && (bx < X_LIM) && (by < Y_LIM);
   end

   always_comb begin
      frame_end   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
      h_cnt_d     = h_cnt_q + 10'd1;
      v_cnt_d     = v_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = 10'd0;
         v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end
      if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;

      sh_en_d    = sh_en_q;
      sh_blink_d = sh_blink_q;
      sh_x_d     = sh_x_q;
      sh_y_d     = sh_y_q;
      sh_half_d  = sh_half_q;
      sh_color_d = sh_color_q;
      if (frame_end) begin
         sh_en_d    = cfg.box_en;
         sh_blink_d = cfg.box_blink;
         sh_x_d     = cfg.box_x;
         sh_y_d     = cfg.box_y;
         sh_half_d  = cfg.box_half;
         sh_color_d = cfg.box_color;
      end

      hit_d = '0;
      for (int i = 0; i < NUM_BOXES; i++) begin
         hit_d[i] = drawable[i] && (h_ext >= left[i]) && (h_ext <= right[i])
                    && (v_ext >= top[i]) && (v_ext <= bottom[i]);
      end
      act1_d = (h_cnt_q < W_LIM) && (v_cnt_q < V_LIM);
      hs1_d  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
      vs1_d  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

      // Ascending scan: the last (highest-index) hit overrides earlier ones.
      pix = cfg.bg_color;
      for (int i = 0; i < NUM_BOXES; i++) begin
         if (hit_q[i]) pix = sh_color_q[12*i +: 12];
      end
      rgb_d = act1_q ? pix : 12'h000;
      hs2_d = hs1_q;
      vs2_d = vs1_q;
   end

   always_ff @(posedge clk_25mHz) begin
      if (reset) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
         sh_en_q     <= '0;
         sh_blink_q  <= '0;
         sh_x_q      <= '0;
         sh_y_q      <= '0;
         sh_half_q   <= '0;
         sh_color_q  <= '0;
         hit_q       <= '0;
         act1_q      <= 1'b0;
         hs1_q       <= 1'b1;
         vs1_q       <= 1'b1;
         rgb_q       <= '0;
         hs2_q       <= 1'b1;
         vs2_q       <= 1'b1;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         sh_en_q     <= sh_en_d;
         sh_blink_q  <= sh_blink_d;
         sh_x_q      <= sh_x_d;
         sh_y_q      <= sh_y_d;
         sh_half_q   <= sh_half_d;
         sh_color_q  <= sh_color_d;
         hit_q       <= hit_d;
         act1_q      <= act1_d;
         hs1_q       <= hs1_d;
         vs1_q       <= vs1_d;
         rgb_q       <= rgb_d;
         hs2_q       <= hs2_d;
         vs2_q       <= vs2_d;
      end
   end

   assign hSync     = hs2_q;
   assign vSync     = vs2_q;
   assign {VGA_R, VGA_G, VGA_B} = rgb_q;
   assign screenEnd = frame_end;
   assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_box_compositor.sv
// Bench for vga_box_compositor. The main instance uses a reduced raster so
// many frames fit in a short run; a second, tiny-raster instance covers the
// 256-frame frame_cnt wrap. The reference model works from a cycle index
// since reset and per-frame descriptor snapshots.
module tb_vga_box_compositor;
   localparam int PW = 64, PH = 40;
   localparam int HFP = 4, HSW = 8, HBP = 4;
   localparam int VFP = 2, VSW = 2, VBP = 4;
   localparam int NB = 4, BS = 1;
   localparam int HT = PW + HFP + HSW + HBP;
   localparam int VT = PH + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;
   localparam int TF = 7 * 5;

   logic clk, rst, rst_t;
   logic hSync, vSync, screenEnd;
   logic [3:0] VGA_R, VGA_G, VGA_B;
   logic [7:0] frame_cnt;
   logic hs_t, vs_t, se_t;
   logic [3:0] r_t, g_t, b_t;
   logic [7:0] fc_t;

   vga_box_compositor_if #(.NUM_BOXES(NB)) cfg ();
   vga_box_compositor_if #(.NUM_BOXES(1))  cfg_t ();

   vga_box_compositor #(
      .WIDTH(PW), .HEIGHT(PH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .NUM_BOXES(NB), .BLINK_SHIFT(BS)
   ) dut (
      .clk_25mHz(clk), .reset(rst), .cfg(cfg), .hSync(hSync), .vSync(vSync),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .screenEnd(screenEnd),
      .frame_cnt(frame_cnt)
   );

   vga_box_compositor #(
      .WIDTH(4), .HEIGHT(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_FP(1), .V_SYNC(1), .V_BP(1), .NUM_BOXES(1), .BLINK_SHIFT(4)
   ) dut_t (
      .clk_25mHz(clk), .reset(rst_t), .cfg(cfg_t), .hSync(hs_t), .vSync(vs_t),
      .VGA_R(r_t), .VGA_G(g_t), .VGA_B(b_t), .screenEnd(se_t),
      .frame_cnt(fc_t)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   typedef struct {
      bit          en;
      bit          blink;
      int          x;
      int          y;
      int          half;
      logic [11:0] col;
   } box_t;

   typedef struct {
      int          phase;
      int          h;
      int          v;
      logic [11:0] rgb;
   } probe_t;

   box_t        snap [2][NB];
   probe_t      probes [$];
   logic [11:0] obs [PW][PH];
   logic [11:0] bg_edge;
   int          t;
   int          vectors, miscompares;
   bit          checking, count_en, tiny_done;
   int          hs_low, vs_low, se_seen;

   function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
   function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

   // Colour the spec's rules give for the pixel shown at cycle index s.
   function automatic logic [11:0] pixel_col(int s, logic [11:0] bg);
      int f, p, h, v;
      logic [11:0] c;
      box_t b;
      f = s / FRAME;
      p = s % FRAME;
      h = p % HT;
      v = p / HT;
      if (h >= PW || v >= PH) return 12'h000;
      c = bg;
      for (int i = 0; i < NB; i++) begin
         b = snap[f % 2][i];
         if (b.en && !(b.blink && (((f % 256) >> BS) & 1) == 1)
             && b.x < PW && b.y < PH
             && h >= imax(b.x - b.half, 0) && h <= imin(b.x + b.half, PW - 1)
             && v >= imax(b.y - b.half, 0) && v <= imin(b.y + b.half, PH - 1))
            c = b.col;
      end
      return c;
   endfunction

   task automatic cmp(string name, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check();
      logic [11:0] e_rgb, a_rgb;
      logic e_hs, e_vs, e_se;
      logic [7:0] e_fc;
      int s, p, h, v;
      a_rgb = {VGA_R, VGA_G, VGA_B};
      e_rgb = 12'h000;
      e_hs = 1'b1;
      e_vs = 1'b1;
      if (t >= 2) begin
         s = t - 2;
         p = s % FRAME;
         h = p % HT;
         v = p / HT;
         e_rgb = pixel_col(s, bg_edge);
         e_hs = !(h >= PW + HFP && h < PW + HFP + HSW);
         e_vs = !(v >= PH + VFP && v < PH + VFP + VSW);
         if (h < PW && v < PH) obs[h][v] = a_rgb;
      end
      e_se = ((t % FRAME) == FRAME - 1);
      e_fc = 8'((t / FRAME) % 256);
      vectors++;
      if ({hSync, vSync, a_rgb, screenEnd, frame_cnt} !== {e_hs, e_vs, e_rgb, e_se, e_fc}) begin
         miscompares++;
         $display("FAIL cycle t=%0d: got hs=%b vs=%b rgb=%h se=%b fc=%0d, expected hs=%b vs=%b rgb=%h se=%b fc=%0d",
                  t, hSync, vSync, a_rgb, screenEnd, frame_cnt, e_hs, e_vs, e_rgb, e_se, e_fc);
      end
      if (count_en) begin
         if (!hSync) hs_low++;
         if (!vSync) vs_low++;
         if (screenEnd) se_seen++;
      end
   endtask

   // Advance one clock; inputs currently driven are what the edge samples.
   task automatic tick();
      int tn;
      if (rst) begin
         tn = 0;
         for (int i = 0; i < NB; i++) begin
            snap[0][i] = '{0, 0, 0, 0, 0, 12'h000};
            snap[1][i] = '{0, 0, 0, 0, 0, 12'h000};
         end
      end else begin
         if (t % FRAME == FRAME - 1) begin
            for (int i = 0; i < NB; i++) begin
               snap[((t / FRAME) + 1) % 2][i] = '{cfg.box_en[i], cfg.box_blink[i],
                  int'(cfg.box_x[10*i +: 10]), int'(cfg.box_y[9*i +: 9]),
                  int'(cfg.box_half[8*i +: 8]), cfg.box_color[12*i +: 12]};
            end
         end
         tn = t + 1;
      end
      bg_edge = cfg.bg_color;
      @(negedge clk);
      t = tn;
      checking = 1'b1;
      check();
   endtask

   task automatic run_to(int target);
      while (t < target) tick();
   endtask

   task automatic set_box(int i, bit en, bit blink, int x, int y, int half, logic [11:0] col);
      cfg.box_en[i]           = en;
      cfg.box_blink[i]        = blink;
      cfg.box_x[10*i +: 10]   = 10'(x);
      cfg.box_y[9*i +: 9]     = 9'(y);
      cfg.box_half[8*i +: 8]  = 8'(half);
      cfg.box_color[12*i +: 12] = col;
   endtask

   task automatic check_probes(int ph);
      foreach (probes[k]) begin
         if (probes[k].phase == ph) begin
            vectors++;
            if (obs[probes[k].h][probes[k].v] !== probes[k].rgb) begin
               miscompares++;
               $display("FAIL probe phase %0d pixel (%0d,%0d): got %h expected %h", ph,
                        probes[k].h, probes[k].v, obs[probes[k].h][probes[k].v], probes[k].rgb);
            end
         end
      end
   endtask

   // Frame counter wrap on the tiny raster (35 clocks per frame).
   initial begin
      int c, se_cnt;
      cfg_t.box_en = '0; cfg_t.box_blink = '0; cfg_t.box_x = '0; cfg_t.box_y = '0;
      cfg_t.box_half = '0; cfg_t.box_color = '0; cfg_t.bg_color = 12'h000;
      tiny_done = 1'b0;
      rst_t = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_t = 1'b0;
      c = 0;
      se_cnt = 0;
      while (c <= TF * 256) begin
         if (se_t) se_cnt++;
         if (c == TF * 256 - 1) begin
            cmp("wrap fc before", int'(fc_t), 255);
            cmp("wrap se", int'(se_t), 1);
         end
         if (c == TF * 256) cmp("wrap fc after", int'(fc_t), 0);
         if (c < TF * 256) @(negedge clk);
         c++;
      end
      cmp("tiny screenEnd count", se_cnt, 256);
      tiny_done = 1'b1;
   end

   initial begin
      int n;
      probes.push_back('{0, 25, 15, 12'h0F0});
      probes.push_back('{0, 35, 25, 12'h0F0});
      probes.push_back('{0, 30, 20, 12'h0F0});
      probes.push_back('{0, 24, 20, 12'h111});
      probes.push_back('{0, 36, 20, 12'h111});
      probes.push_back('{0, 30, 14, 12'h111});
      probes.push_back('{0, 30, 26, 12'h111});
      probes.push_back('{1,  8,  8, 12'hF00});
      probes.push_back('{1,  0,  0, 12'h00F});
      probes.push_back('{1, 15, 15, 12'h00F});
      probes.push_back('{1,  6,  6, 12'hF00});
      probes.push_back('{1, 14, 14, 12'hF00});
      probes.push_back('{1, 25, 25, 12'h00F});
      probes.push_back('{1, 26, 25, 12'h111});
      probes.push_back('{1, 50, 10, 12'h111});
      probes.push_back('{1, 40, 30, 12'h111});
      probes.push_back('{2, 20, 23, 12'h0F0});
      probes.push_back('{2, 17, 17, 12'h0F0});
      probes.push_back('{2, 40, 23, 12'h111});
      probes.push_back('{3, 40, 17, 12'h0F0});
      probes.push_back('{3, 43, 23, 12'h0F0});
      probes.push_back('{3, 20, 17, 12'h111});
      probes.push_back('{4, 50, 30, 12'hF0F});
      probes.push_back('{4, 48, 28, 12'hF0F});
      probes.push_back('{4, 47, 30, 12'h111});
      probes.push_back('{5, 50, 30, 12'h111});
      probes.push_back('{6, 50, 30, 12'h111});
      probes.push_back('{7, 50, 30, 12'hF0F});

      vectors = 0; miscompares = 0; checking = 0; count_en = 0;
      hs_low = 0; vs_low = 0; se_seen = 0; t = 0;
      cfg.box_en = '0; cfg.box_blink = '0; cfg.box_x = '0; cfg.box_y = '0;
      cfg.box_half = '0; cfg.box_color = '0; cfg.bg_color = 12'h111;
      rst = 1'b1;
      @(negedge clk);
      repeat (3) tick();
      rst = 1'b0;
      cmp("reset hSync", int'(hSync), 1);
      cmp("reset vSync", int'(vSync), 1);
      cmp("reset rgb", int'({VGA_R, VGA_G, VGA_B}), 0);

      // Single box, inclusive edges; also sync and frame pulse counts.
      set_box(0, 1, 0, 30, 20, 5, 12'h0F0);
      count_en = 1'b1;
      run_to(2 * FRAME);
      count_en = 1'b0;
      cmp("hSync low clocks in 2 frames", hs_low, 2 * VT * HSW);
      cmp("vSync low clocks in 2 frames", vs_low, 2 * VSW * HT);
      cmp("screenEnd pulses in 2 frames", se_seen, 2);
      check_probes(0);

      // Priority, clamping, off-screen centres.
      set_box(0, 1, 0, 5, 5, 20, 12'h00F);
      set_box(1, 1, 0, 40, 45, 20, 12'h0FF);
      set_box(2, 1, 0, 70, 10, 40, 12'hFFF);
      set_box(3, 1, 0, 10, 10, 4, 12'hF00);
      run_to(4 * FRAME);
      check_probes(1);

      // Shadow latch: x changes mid-frame 5, takes effect in frame 6.
      set_box(0, 1, 0, 20, 20, 3, 12'h0F0);
      for (int i = 1; i < NB; i++) cfg.box_en[i] = 1'b0;
      run_to(5 * FRAME + 20 * HT);
      cfg.box_x[9:0] = 10'd40;
      run_to(6 * FRAME);
      check_probes(2);
      run_to(7 * FRAME);
      check_probes(3);

      // Blink: visible in frame 8, hidden in frame 10.
      cfg.box_en[0] = 1'b0;
      set_box(1, 1, 1, 50, 30, 2, 12'hF0F);
      run_to(9 * FRAME);
      check_probes(4);
      run_to(11 * FRAME);
      check_probes(5);

      // Reset at pixel (40,30).
      run_to(11 * FRAME + 30 * HT + 40);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmp("mid reset rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
      cmp("mid reset hSync", int'(hSync), 1);
      cmp("mid reset vSync", int'(vSync), 1);
      cmp("mid reset frame_cnt", int'(frame_cnt), 0);
      n = 0;
      while (!screenEnd && n < 2 * FRAME) begin
         tick();
         n++;
      end
      cmp("clocks to first screenEnd after reset", n, FRAME - 1);
      run_to(FRAME);
      check_probes(6);
      run_to(2 * FRAME);
      check_probes(7);

      // Random descriptors changing at arbitrary cycles.
      while (t < 4 * FRAME) begin
         if ($urandom_range(63) == 0) begin
            for (int i = 0; i < NB; i++)
               set_box(i, 1'($urandom_range(1)), 1'($urandom_range(1)),
                       $urandom_range(80), $urandom_range(50), $urandom_range(40),
                       12'($urandom));
         end
         if ($urandom_range(255) == 0) cfg.bg_color = 12'($urandom);
         tick();
      end

      cmp("tiny wrap test completed", int'(tiny_done), 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
